// File: rtl/cell_pixel_writer_pkg.sv
// Shared cell-processing types: pixel format and the writer FSM state encoding.
package CellProcessingPkg;
  localparam int PIXEL_W = 8;

  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} wr_state_e;
endpackage

// File: rtl/writer_word_fifo.sv
// Synchronous show-ahead word FIFO: dout is the head entry whenever !empty.
// Push and pop together on a full FIFO both take effect.
module writer_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rptr_q];
  assign count   = cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end
endmodule

// File: rtl/cell_pixel_writer.sv
// Packs the processed pixel stream into memory words, queues them and writes them
// to sequential addresses. Define WRITER_PERF_EN to add the stall_cycles counter.
module cell_pixel_writer
  import CellProcessingPkg::*;
#(
  parameter int PIX_PER_WORD = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = 16,
  parameter int DIM_W        = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            frame_start,
  input  logic [DIM_W-1:0]                img_width,
  input  logic [DIM_W-1:0]                img_height,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic                            pixel_valid,
  input  pixel_t                          processedPixel,
  output logic                            pixel_ready,
  output logic                            wr_en,
  output logic [ADDR_W-1:0]               wr_addr,
  output logic [PIX_PER_WORD*PIXEL_W-1:0] wr_data,
  input  logic                            mem_ready,
  output logic                            frame_done,
  output logic                            err_drop
`ifdef WRITER_PERF_EN
  ,
  output logic [31:0]                     stall_cycles
`endif
);
  localparam int WW = PIX_PER_WORD * PIXEL_W;
  localparam int LW = $clog2(PIX_PER_WORD);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wr_state_e         state_q, state_d;
  logic [DIM_W-1:0]  w_q, h_q, col_q, row_q;
  logic [LW-1:0]     lane_q;
  logic [WW-1:0]     pack_q, pack_ins, stage_q, fifo_head;
  logic              stage_vld_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              start, accept, col_last, row_last, word_done, frame_last, pop;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_cnt;

  assign start      = (state_q == IDLE) && frame_start;
  assign accept     = pixel_valid && pixel_ready;
  assign col_last   = (col_q == w_q - DIM_W'(1));
  assign row_last   = (row_q == h_q - DIM_W'(1));
  assign word_done  = accept && ((lane_q == LW'(PIX_PER_WORD - 1)) || col_last);
  assign frame_last = accept && col_last && row_last;
  assign pop        = wr_en && mem_ready;

  // The staged word lands in the FIFO next edge, so it already claims a slot.
  assign pixel_ready = (state_q == RUN) && !fifo_full &&
                       !(stage_vld_q && (fifo_cnt == CW'(FIFO_DEPTH - 1)));
  assign wr_en       = !fifo_empty;
  assign wr_data     = fifo_empty ? '0 : fifo_head;
  assign wr_addr     = addr_q;
  assign frame_done  = (state_q == DONE);
  assign err_drop    = err_q;

  always_comb begin
    pack_ins = pack_q;
    pack_ins[lane_q*PIXEL_W +: PIXEL_W] = processedPixel;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (frame_start)
               state_d = (img_width == '0 || img_height == '0) ? DONE : RUN;
      RUN:   if (frame_last) state_d = FLUSH;
      // Leave as soon as the final write completes so frame_done follows it directly.
      FLUSH: if (!stage_vld_q && (fifo_empty || (fifo_cnt == CW'(1) && pop)))
               state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      w_q         <= '0;
      h_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      stage_q     <= '0;
      stage_vld_q <= 1'b0;
      addr_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_vld_q <= word_done;
      if (word_done) stage_q <= pack_ins;
      if (pop) addr_q <= addr_q + ADDR_W'(1);
      if (start) begin
        w_q    <= img_width;
        h_q    <= img_height;
        addr_q <= base_addr;
        col_q  <= '0;
        row_q  <= '0;
        lane_q <= '0;
        pack_q <= '0;
      end else if (accept) begin
        if (word_done) begin
          pack_q <= '0;
          lane_q <= '0;
        end else begin
          pack_q <= pack_ins;
          lane_q <= lane_q + LW'(1);
        end
        if (col_last) begin
          col_q <= '0;
          row_q <= row_q + DIM_W'(1);
        end else begin
          col_q <= col_q + DIM_W'(1);
        end
      end
      if (pixel_valid && state_q != RUN) err_q <= 1'b1;
    end
  end

  writer_word_fifo #(.WIDTH(WW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (stage_vld_q),
    .pop   (pop),
    .din   (stage_q),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

`ifdef WRITER_PERF_EN
  logic [31:0] stall_q;
  logic        stall_ev;

  assign stall_ev = (wr_en && !mem_ready) ||
                    (state_q == RUN && pixel_valid && !pixel_ready);
  assign stall_cycles = stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           stall_q <= '0;
    else if (start)                     stall_q <= '0;
    else if (stall_ev && stall_q != '1) stall_q <= stall_q + 32'd1;
  end
`endif
endmodule

// File: tb/tb_cell_pixel_writer.sv
// Directed bench for cell_pixel_writer: packing, row padding, back-pressure,
// empty frames, dropped pixels and mid-frame reset.
module tb_cell_pixel_writer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  img_width = '0, img_height = '0;
  logic [15:0] base_addr = '0;
  logic        pixel_valid = 1'b0;
  logic [7:0]  processedPixel = '0;
  logic        pixel_ready, wr_en, mem_ready = 1'b1, frame_done, err_drop;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
`ifdef WRITER_PERF_EN
  logic [31:0] stall_cycles;
`endif

  int n_run = 0, n_fail = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
  logic [15:0] got_a[$];
  logic [31:0] got_d[$];

  cell_pixel_writer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .img_width(img_width), .img_height(img_height), .base_addr(base_addr),
    .pixel_valid(pixel_valid), .processedPixel(processedPixel),
    .pixel_ready(pixel_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_ready(mem_ready), .frame_done(frame_done), .err_drop(err_drop)
`ifdef WRITER_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en && mem_ready) begin
      got_a.push_back(wr_addr);
      got_d.push_back(wr_data);
      last_wr_cyc <= cyc;
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int k, input logic [15:0] a, input logic [31:0] d);
    chk({tag, "_addr"}, (k < got_a.size()) ? 64'(got_a[k]) : 64'hDEAD_DEAD_DEAD, 64'(a));
    chk({tag, "_data"}, (k < got_d.size()) ? 64'(got_d[k]) : 64'hDEAD_DEAD_DEAD, 64'(d));
  endtask

  // All tasks run with the bench positioned 1ns after a rising edge.
  task automatic start(input int w, input int h, input logic [15:0] base);
    frame_start = 1'b1;
    img_width   = 10'(w);
    img_height  = 10'(h);
    base_addr   = base;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic feed(input int n, input logic [7:0] v0);
    int i = 0;
    int t = 0;
    while (i < n && t < 2000) begin
      pixel_valid    = 1'b1;
      processedPixel = v0 + 8'(i);
      @(negedge clk);
      if (pixel_ready) i++;
      @(posedge clk); #1;
      t++;
    end
    pixel_valid = 1'b0;
    if (i < n) chk("feed_timeout", 64'(i), 64'(n));
  endtask

  task automatic wait_done(input string tag, input int n0);
    int t = 0;
    while (done_cnt == n0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    @(posedge clk); #1;
    chk({tag, "_done_pulses"}, 64'(done_cnt - n0), 64'd1);
  endtask

  initial begin
    int n0, c0;
    logic moved;
    logic [7:0] b;

    // Reset state
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_ready", pixel_ready, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", err_drop, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: 8x2 frame, free-flowing memory
    got_a.delete(); got_d.delete(); n0 = done_cnt;
    start(8, 2, 16'h0100);
    feed(16, 8'h00);
    wait_done("t1", n0);
    chk("t1_nwr", got_a.size(), 4);
    chk_wr("t1_w0", 0, 16'h0100, 32'h03020100);
    chk_wr("t1_w1", 1, 16'h0101, 32'h07060504);
    chk_wr("t1_w2", 2, 16'h0102, 32'h0B0A0908);
    chk_wr("t1_w3", 3, 16'h0103, 32'h0F0E0D0C);
    chk("t1_done_after_last_wr", 64'(done_cyc - last_wr_cyc), 64'd1);
    chk("t1_err", err_drop, 0);

    // 2: 6x1 frame, partial word padded at row end
    got_a.delete(); got_d.delete(); n0 = done_cnt;
    start(6, 1, 16'h0040);
    feed(6, 8'hA0);
    wait_done("t2", n0);
    chk("t2_nwr", got_a.size(), 2);
    chk_wr("t2_w0", 0, 16'h0040, 32'hA3A2A1A0);
    chk_wr("t2_w1", 1, 16'h0041, 32'h0000A5A4);

    // 3: memory stalled 40 cycles during 8x4 frame, address wraps past 0xFFFF
    got_a.delete(); got_d.delete(); n0 = done_cnt;
    mem_ready = 1'b0;
    c0 = cyc;
    moved = 1'b0;
    start(8, 4, 16'hFFFE);
    feed(32, 8'h40);
    while (cyc < c0 + 40) begin
      @(negedge clk);
      if (wr_addr !== 16'hFFFE) moved = 1'b1;
      @(posedge clk); #1;
    end
    chk("t3_addr_hold", moved, 0);
    chk("t3_addr", wr_addr, 16'hFFFE);
    chk("t3_wr_en", wr_en, 1);
    chk("t3_ready", pixel_ready, 0);
    chk("t3_no_wr", got_a.size(), 0);
    mem_ready = 1'b1;
    wait_done("t3", n0);
    chk("t3_nwr", got_a.size(), 8);
    for (int k = 0; k < 8; k++) begin
      b = 8'h40 + 8'(4 * k);
      chk_wr($sformatf("t3_w%0d", k), k, 16'hFFFE + 16'(k),
             {b + 8'd3, b + 8'd2, b + 8'd1, b});
    end

    // 4: zero-width frame completes immediately with no writes
    got_a.delete(); got_d.delete(); n0 = done_cnt;
    c0 = cyc;
    start(0, 3, 16'h0800);
    wait_done("t4", n0);
    chk("t4_done_cyc", 64'(done_cyc - c0), 64'd1);
    chk("t4_nwr", got_a.size(), 0);

    // 5: pixel in IDLE is dropped; restart during RUN is ignored
    got_a.delete(); got_d.delete(); n0 = done_cnt;
    pixel_valid = 1'b1;
    processedPixel = 8'hEE;
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    chk("t5_err_set", err_drop, 1);
    start(4, 1, 16'h0500);
    feed(2, 8'h30);
    start(2, 1, 16'h0777);
    feed(2, 8'h32);
    wait_done("t5", n0);
    chk("t5_nwr", got_a.size(), 1);
    chk_wr("t5_w0", 0, 16'h0500, 32'h33323130);
    chk("t5_err_sticky", err_drop, 1);

    // 6: reset mid-frame with a queued word, then a fresh 4x1 frame
    mem_ready = 1'b0;
    start(8, 1, 16'h0200);
    feed(5, 8'h60);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_wr_en", wr_en, 0);
    chk("t6_rst_err", err_drop, 0);
    chk("t6_rst_addr", wr_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mem_ready = 1'b1;
    got_a.delete(); got_d.delete(); n0 = done_cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_no_stale", got_a.size(), 0);
    start(4, 1, 16'h0300);
    feed(4, 8'h11);
    @(negedge clk);
    chk("t6_lat_e1", wr_en, 0);
    @(negedge clk);
    chk("t6_lat_e2", wr_en, 1);
    @(posedge clk); #1;
    wait_done("t6", n0);
    chk("t6_nwr", got_a.size(), 1);
    chk_wr("t6_w0", 0, 16'h0300, 32'h14131211);
`ifdef WRITER_PERF_EN
    chk("t6_stall", stall_cycles, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
